multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle RV32I control unit: Moore FSM plus combinational ALU decode driving the shared-memory multicycle datapath. Adds a memory valid/ready handshake with wait states, the full branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU), JALR, LUI and AUIPC. Detects illegal instructions and traps on them. Sits between the instruction register (op/funct fields), the datapath flags and the unified instruction/data memory port.

## Interface
- MEM_HANDSHAKE, 1, 1: wait on `mem_ready`; 0: `mem_ready` treated as constant 1 (no wait states).
- TRAP_ON_ILLEGAL, 1, 1: illegal instruction enters TRAP and stays there until reset; 0: one-cycle TRAP, then FETCH.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- op  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero, Lt, Ltu  in  1 each  flags from the ALU SUB result: equal, signed less-than, unsigned less-than.
- mem_ready  in  1  memory completes the access this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  write strobe.
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut.
- IRWrite, PCWrite, RegWrite  out  1 each  register enables.
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  ALU B select: 00 rs2, 01 ImmExt, 10 constant 4.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControl  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
- Illegal  out  1  high while in TRAP.
- state_o  out  4  current state encoding, debug only.

## Operation
- Output defaults: all enables 0, all selects 0, ALUControl ADD.
- FETCH
  - Outputs: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite and PCWrite assert only in the cycle `mem_ready`=1; that cycle moves to DECODE. Otherwise stay in FETCH.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, ADD; ImmSrc=J if op=JAL, else B. This precomputes the branch/jump target into ALUOut.
  - Next state by op:
    - LW/SW → MEMADR
    - R-type → EXECUTER
    - I-ALU → EXECUTEI
    - JAL → JAL
    - JALR → JALR
    - BRANCH → BRANCH
    - LUI/AUIPC → UPPER
    - anything else → TRAP
  - Also TRAP: load/store with funct3≠010; branch with funct3 010/011; JALR with funct3≠000.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD; ImmSrc=I for load, S for store. Next: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: MemReq=1, AdrSrc=1. Hold until `mem_ready`, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, held stable while waiting. On `mem_ready` go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, R-type decode. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, I-type decode. Both go to ALUWB.
- ALU decode from funct3:
  - 000: ADD; SUB only for R-type with funct7b5=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRA if funct7b5=1, else SRL (R- and I-type).
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, ADD. Next JAL.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. This writes PC=ALUOut and computes OldPC+4. Next ALUWB. The datapath clears PC bit 0.
- BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00. Next FETCH.
  - PCWrite = taken, where taken by funct3 is: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu.
- UPPER: ALUSrcA = 01 if op[5]=0 (AUIPC), 11 if op[5]=1 (LUI); ALUSrcB=01, ImmSrc=U, ADD. Next ALUWB.
- TRAP: Illegal=1, all enables 0. Sticky if TRAP_ON_ILLEGAL=1, else next FETCH (PC already advanced).

## Timing
- State register flops on posedge clk. Async reset forces FETCH.
- While `reset`=1, MemReq/IRWrite/PCWrite/RegWrite/MemWrite are forced 0. All other outputs take FETCH values, Illegal=0, state_o=0.
- Outputs are combinational from state. PCWrite and IRWrite additionally depend on flags and `mem_ready` (Mealy).
- CPI with zero wait states:
  - 5: LW
  - 4: SW, R-type, I-ALU, UPPER, JAL
  - 3: BRANCH
  - 5: JALR
  - Each memory wait cycle adds 1.
- Reset mid-access drops MemReq in the same cycle; no MemWrite pulse may escape.
- `mem_ready` outside MemReq is ignored.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum (4 bits)
  - opcode constants
  - ALUControl, ImmSrc, ALUSrcA/B and ResultSrc encodings
- One sub-module `alu_ctrl_dec`: combinational (state-class, funct3, funct7b5) → ALUControl.

## Test plan
- ADDI x1,x0,5 with `mem_ready` always 1 → FETCH,DECODE,EXECUTEI,ALUWB; RegWrite in cycle 4; ALUControl=0000.
- LW with `mem_ready` low 2 cycles in FETCH and 3 in MEMREAD → IRWrite/PCWrite exactly once; MemReq steady; RegWrite with ResultSrc=01 after 10 cycles.
- BLT (funct3 100): Lt=1 → PCWrite=1 in BRANCH; Lt=0 → PCWrite=0; BGEU (111) with Ltu=0 → taken.
- JALR → states JALR,JAL,ALUWB; PCWrite in JAL with ResultSrc=00; RegWrite in ALUWB.
- op=7'b1111111: TRAP_ON_ILLEGAL=1 → Illegal stuck high, no enables until reset. TRAP_ON_ILLEGAL=0 → one-cycle pulse, then FETCH.
- Reset asserted mid-MEMWRITE → MemWrite/MemReq 0 immediately; after release, FETCH with state_o=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes and datapath selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_BRANCH   = 4'd11,
        S_UPPER    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    // Selects which operation source the ALU decoder uses this state.
    typedef enum logic [1:0] {
        AC_ADD = 2'd0,
        AC_SUB = 2'd1,
        AC_R   = 2'd2,
        AC_I   = 2'd3
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Dispatch out of DECODE; unsupported opcodes and funct3 values fall into TRAP.
    function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] funct3);
        state_t nxt;
        nxt = S_TRAP;
        case (op)
            OP_LOAD, OP_STORE: nxt = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
            OP_RTYPE:          nxt = S_EXECUTER;
            OP_ITYPE:          nxt = S_EXECUTEI;
            OP_JAL:            nxt = S_JAL;
            OP_JALR:           nxt = (funct3 == 3'b000) ? S_JALR : S_TRAP;
            OP_BRANCH:         nxt = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
            OP_LUI, OP_AUIPC:  nxt = S_UPPER;
            default:           nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU operation decode from state class and funct fields; no latency, no flow control.
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  alu_class_t  cls,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [3:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (cls)
            AC_ADD: alu_control = ALU_ADD;
            AC_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // Immediate forms have no SUB; bit 30 there is part of the immediate.
                    3'b000:  alu_control = (cls == AC_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: Moore outputs per state, Mealy IRWrite/PCWrite on mem_ready and branch flags.
// Memory states hold their request stable until mem_ready; illegal opcodes enter TRAP.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       Ltu,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] state_o
);

    state_t     state, state_nxt;
    alu_class_t alu_cls;
    logic       rdy, taken;
    logic       mem_req, mem_write, ir_write, pc_write, reg_write;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = Lt;
            3'b101:  taken = ~Lt;
            3'b110:  taken = Ltu;
            3'b111:  taken = ~Ltu;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        alu_cls   = AC_ADD;
        Illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (rdy) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = (op == OP_JAL) ? IMM_J : IMM_B;
                state_nxt = decode_next(op, funct3);
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = op[5] ? IMM_S : IMM_I;
                state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (rdy) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                AdrSrc    = 1'b1;
                if (rdy) state_nxt = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                alu_cls   = AC_R;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                alu_cls   = AC_I;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = S_JAL;
            end
            // PC takes the target held in ALUOut while the ALU forms the link address.
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_write  = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                alu_cls   = AC_SUB;
                pc_write  = taken;
                state_nxt = S_FETCH;
            end
            S_UPPER: begin
                ALUSrcA   = op[5] ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_U;
                state_nxt = S_ALUWB;
            end
            S_TRAP: begin
                Illegal   = 1'b1;
                state_nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .cls         (alu_cls),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    // Gate strobes with reset so nothing escapes in the cycle reset arrives.
    assign MemReq   = mem_req   & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign IRWrite  = ir_write  & ~reset;
    assign PCWrite  = pc_write  & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign state_o  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: sticky-trap and one-cycle-trap instances share stimulus.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0;
    logic       mem_ready = 1'b1;

    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl, state_o;

    logic       MemReq_t0, MemWrite_t0, AdrSrc_t0, IRWrite_t0, PCWrite_t0, RegWrite_t0, Illegal_t0;
    logic [1:0] ResultSrc_t0, ALUSrcA_t0, ALUSrcB_t0;
    logic [2:0] ImmSrc_t0;
    logic [3:0] ALUControl_t0, state_o_t0;

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal),
        .state_o(state_o)
    );

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut_t0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
        .MemReq(MemReq_t0), .MemWrite(MemWrite_t0), .AdrSrc(AdrSrc_t0), .IRWrite(IRWrite_t0),
        .PCWrite(PCWrite_t0), .RegWrite(RegWrite_t0), .ResultSrc(ResultSrc_t0),
        .ALUSrcA(ALUSrcA_t0), .ALUSrcB(ALUSrcB_t0), .ImmSrc(ImmSrc_t0),
        .ALUControl(ALUControl_t0), .Illegal(Illegal_t0), .state_o(state_o_t0)
    );

    always #5 clk = ~clk;

    // Word layout: state, {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite}, ResultSrc,
    // ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal.
    localparam logic [23:0] E_RST   = {4'd0,  6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_F1    = {4'd0,  6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_F0    = {4'd0,  6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_DB    = {4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 4'b0000, 1'b0};
    localparam logic [23:0] E_EXI   = {4'd7,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_EXSRA = {4'd7,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b1001, 1'b0};
    localparam logic [23:0] E_EXSUB = {4'd6,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 1'b0};
    localparam logic [23:0] E_WB    = {4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_MAL   = {4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_MAS   = {4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 1'b0};
    localparam logic [23:0] E_MR    = {4'd3,  6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_MWB   = {4'd4,  6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_MW    = {4'd5,  6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_BRT   = {4'd11, 6'b000010, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 1'b0};
    localparam logic [23:0] E_BRN   = {4'd11, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 1'b0};
    localparam logic [23:0] E_JR    = {4'd10, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_J     = {4'd9,  6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 1'b0};
    localparam logic [23:0] E_LUI   = {4'd12, 6'b000000, 2'b00, 2'b11, 2'b01, 3'b100, 4'b0000, 1'b0};
    localparam logic [23:0] E_AUI   = {4'd12, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b100, 4'b0000, 1'b0};
    localparam logic [23:0] E_TRAP  = {4'd13, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1};

    // Second-instance expectation {state, Illegal}; SAME means it tracks the primary word.
    localparam logic [4:0] SAME   = 5'h1F;
    localparam logic [4:0] T0_FET = 5'b0000_0;

    typedef struct packed {
        logic [23:0] v;
        logic [4:0]  alt;
    } exp_t;

    exp_t  sb[$];
    string nmq[$];
    int    vecs = 0;
    int    miscompares = 0;

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic cyc(input string nm, input logic rdy, input logic [2:0] flg,
                       input logic [23:0] v, input logic [4:0] alt);
        exp_t e;
        mem_ready = rdy;
        {Zero, Lt, Ltu} = flg;
        e.v = v;
        e.alt = alt;
        sb.push_back(e);
        nmq.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        exp_t e;
        reset = 1'b1;
        mem_ready = 1'b1;
        e.v = E_RST;
        e.alt = SAME;
        sb.push_back(e);
        nmq.push_back(nm);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [23:0] act;
            logic [4:0]  act0, want0;
            e  = sb.pop_front();
            nm = nmq.pop_front();
            act = {state_o, MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
            vecs++;
            if (act !== e.v) begin
                miscompares++;
                $display("FAIL %s: outputs got %h required %h", nm, act, e.v);
            end
            act0  = {state_o_t0, Illegal_t0};
            want0 = (e.alt == SAME) ? {e.v[23:20], e.v[0]} : e.alt;
            vecs++;
            if (act0 !== want0) begin
                miscompares++;
                $display("FAIL %s_t0: state/illegal got %h required %h", nm, act0, want0);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset("reset_init");

        instr(7'b0010011, 3'b000, 1'b0);
        cyc("addi_fetch", 1, 3'b000, E_F1, SAME);
        cyc("addi_dec",   1, 3'b000, E_DB, SAME);
        cyc("addi_exe",   1, 3'b000, E_EXI, SAME);
        cyc("addi_wb",    1, 3'b000, E_WB, SAME);

        instr(7'b0010011, 3'b000, 1'b1);
        cyc("addi7_fetch", 1, 3'b000, E_F1, SAME);
        cyc("addi7_dec",   1, 3'b000, E_DB, SAME);
        cyc("addi7_exe",   1, 3'b000, E_EXI, SAME);
        cyc("addi7_wb",    1, 3'b000, E_WB, SAME);

        instr(7'b0010011, 3'b101, 1'b1);
        cyc("srai_fetch", 1, 3'b000, E_F1, SAME);
        cyc("srai_dec",   1, 3'b000, E_DB, SAME);
        cyc("srai_exe",   1, 3'b000, E_EXSRA, SAME);
        cyc("srai_wb",    1, 3'b000, E_WB, SAME);

        instr(7'b0110011, 3'b000, 1'b1);
        cyc("sub_fetch", 1, 3'b000, E_F1, SAME);
        cyc("sub_dec",   1, 3'b000, E_DB, SAME);
        cyc("sub_exe",   1, 3'b000, E_EXSUB, SAME);
        cyc("sub_wb",    1, 3'b000, E_WB, SAME);

        instr(7'b0000011, 3'b010, 1'b0);
        cyc("lw_fwait1", 0, 3'b000, E_F0, SAME);
        cyc("lw_fwait2", 0, 3'b000, E_F0, SAME);
        cyc("lw_fetch",  1, 3'b000, E_F1, SAME);
        cyc("lw_dec",    1, 3'b000, E_DB, SAME);
        cyc("lw_adr",    1, 3'b000, E_MAL, SAME);
        cyc("lw_rwait1", 0, 3'b000, E_MR, SAME);
        cyc("lw_rwait2", 0, 3'b000, E_MR, SAME);
        cyc("lw_rwait3", 0, 3'b000, E_MR, SAME);
        cyc("lw_read",   1, 3'b000, E_MR, SAME);
        cyc("lw_wb",     1, 3'b000, E_MWB, SAME);

        instr(7'b1100011, 3'b100, 1'b0);
        cyc("blt_t_fetch", 1, 3'b010, E_F1, SAME);
        cyc("blt_t_dec",   1, 3'b010, E_DB, SAME);
        cyc("blt_t_br",    1, 3'b010, E_BRT, SAME);
        cyc("blt_n_fetch", 1, 3'b000, E_F1, SAME);
        cyc("blt_n_dec",   1, 3'b000, E_DB, SAME);
        cyc("blt_n_br",    1, 3'b000, E_BRN, SAME);
        instr(7'b1100011, 3'b111, 1'b0);
        cyc("bgeu_fetch", 1, 3'b000, E_F1, SAME);
        cyc("bgeu_dec",   1, 3'b000, E_DB, SAME);
        cyc("bgeu_br",    1, 3'b000, E_BRT, SAME);

        instr(7'b1100111, 3'b000, 1'b0);
        cyc("jalr_fetch", 1, 3'b000, E_F1, SAME);
        cyc("jalr_dec",   1, 3'b000, E_DB, SAME);
        cyc("jalr_tgt",   1, 3'b000, E_JR, SAME);
        cyc("jalr_jal",   1, 3'b000, E_J, SAME);
        cyc("jalr_wb",    1, 3'b000, E_WB, SAME);

        instr(7'b0110111, 3'b000, 1'b0);
        cyc("lui_fetch", 1, 3'b000, E_F1, SAME);
        cyc("lui_dec",   1, 3'b000, E_DB, SAME);
        cyc("lui_up",    1, 3'b000, E_LUI, SAME);
        cyc("lui_wb",    1, 3'b000, E_WB, SAME);
        instr(7'b0010111, 3'b000, 1'b0);
        cyc("auipc_fetch", 1, 3'b000, E_F1, SAME);
        cyc("auipc_dec",   1, 3'b000, E_DB, SAME);
        cyc("auipc_up",    1, 3'b000, E_AUI, SAME);
        cyc("auipc_wb",    1, 3'b000, E_WB, SAME);

        instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch",  1, 3'b000, E_F1, SAME);
        cyc("sw_dec",    1, 3'b000, E_DB, SAME);
        cyc("sw_adr",    1, 3'b000, E_MAS, SAME);
        cyc("sw_wwait1", 0, 3'b000, E_MW, SAME);
        cyc("sw_wwait2", 0, 3'b000, E_MW, SAME);
        do_reset("sw_reset_mid");
        cyc("sw_post_rst", 0, 3'b000, E_F0, SAME);
        cyc("sw2_fetch", 1, 3'b000, E_F1, SAME);
        cyc("sw2_dec",   1, 3'b000, E_DB, SAME);
        cyc("sw2_adr",   1, 3'b000, E_MAS, SAME);
        cyc("sw2_write", 1, 3'b000, E_MW, SAME);
        cyc("sw2_next",  0, 3'b000, E_F0, SAME);

        instr(7'b0000011, 3'b000, 1'b0);
        cyc("lb_fetch", 1, 3'b000, E_F1, SAME);
        cyc("lb_dec",   1, 3'b000, E_DB, SAME);
        cyc("lb_trap",  1, 3'b000, E_TRAP, SAME);
        cyc("lb_stick", 0, 3'b000, E_TRAP, T0_FET);
        do_reset("lb_reset");

        instr(7'b1100011, 3'b011, 1'b0);
        cyc("br011_fetch", 1, 3'b000, E_F1, SAME);
        cyc("br011_dec",   1, 3'b000, E_DB, SAME);
        cyc("br011_trap",  1, 3'b000, E_TRAP, SAME);
        cyc("br011_stick", 0, 3'b000, E_TRAP, T0_FET);
        do_reset("br011_reset");

        instr(7'b1111111, 3'b000, 1'b0);
        cyc("ill_fetch",  1, 3'b000, E_F1, SAME);
        cyc("ill_dec",    1, 3'b000, E_DB, SAME);
        cyc("ill_trap",   1, 3'b000, E_TRAP, SAME);
        cyc("ill_stick1", 0, 3'b000, E_TRAP, T0_FET);
        cyc("ill_stick2", 0, 3'b000, E_TRAP, T0_FET);
        cyc("ill_stick3", 1, 3'b111, E_TRAP, T0_FET);
        do_reset("ill_reset");
        instr(7'b0010011, 3'b000, 1'b0);
        cyc("ill_post_rst", 0, 3'b000, E_F0, SAME);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: pending got %0d required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
